// File: rtl/fps_meter_pkg.sv
// fps_meter_pkg: shared defaults and saturating increment for the frame-rate meter
package fps_meter_pkg;
  localparam int DEF_GATE_CYCLES = 65_000_000;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_NUM_CH = 3;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic inc, input logic [31:0] max);
    return (inc && a != max) ? a + 32'd1 : a;
  endfunction
endpackage

// File: rtl/fps_meter_chan.sv
// fps_meter_chan: one vsync channel - sync, edge detect, prescale, count, flags, output regs
module fps_meter_chan
  import fps_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV = 1,
  parameter bit EDGE_FALL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             gate_end,
  input  logic             vs,
  output logic [CNT_W-1:0] fps,
  output logic             sat,
  output logic             nosig
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] MAX = '1;
  logic [1:0] sync;
  logic prev, hit, inc, ovf, win_sat, seen;
  logic [PW-1:0] pre;
  logic [CNT_W-1:0] cnt, nxt;
  always_comb begin
    hit = EDGE_FALL ? (prev & ~sync[1]) : (sync[1] & ~prev);
    inc = en && hit && pre == PW'(DIV - 1);
    ovf = inc && cnt == MAX;
    nxt = CNT_W'(sat_add(32'(cnt), inc, 32'(MAX)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
      pre <= '0;
      cnt <= '0;
      win_sat <= 1'b0;
      seen <= 1'b0;
      fps <= '0;
      sat <= 1'b0;
      nosig <= 1'b0;
    end else begin
      sync <= {sync[0], vs};
      prev <= sync[1];
      if (!en) begin
        pre <= '0;
        cnt <= '0;
        win_sat <= 1'b0;
        seen <= 1'b0;
      end else begin
        // prescaler remainder deliberately survives the window boundary
        if (hit) pre <= (pre == PW'(DIV - 1)) ? '0 : pre + 1'b1;
        if (gate_end) begin
          fps <= nxt;
          sat <= win_sat | ovf;
          nosig <= ~(seen | hit);
          cnt <= '0;
          win_sat <= 1'b0;
          seen <= 1'b0;
        end else begin
          cnt <= nxt;
          win_sat <= win_sat | ovf;
          seen <= seen | hit;
        end
      end
    end
  end
endmodule

// File: rtl/fps_meter_multi.sv
// fps_meter_multi: gate-window timer plus NUM_CH independent vsync frame counters
module fps_meter_multi
  import fps_meter_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int DIV = 1,
  parameter bit EDGE_FALL = 1'b1
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    i_en,
  input  logic [NUM_CH-1:0]       i_vs,
  output logic [NUM_CH*CNT_W-1:0] o_fps,
  output logic                    o_valid,
  output logic [NUM_CH-1:0]       o_sat,
  output logic [NUM_CH-1:0]       o_nosig
);
  localparam int GW = $clog2(GATE_CYCLES);
  logic [GW-1:0] gcnt;
  logic gate_end;
  assign gate_end = i_en && gcnt == GW'(GATE_CYCLES - 1);
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      gcnt <= '0;
      o_valid <= 1'b0;
    end else begin
      gcnt <= (!i_en || gate_end) ? '0 : gcnt + 1'b1;
      o_valid <= gate_end;
    end
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    fps_meter_chan #(.CNT_W(CNT_W), .DIV(DIV), .EDGE_FALL(EDGE_FALL)) u_chan (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .en      (i_en),
      .gate_end(gate_end),
      .vs      (i_vs[k]),
      .fps     (o_fps[k*CNT_W +: CNT_W]),
      .sat     (o_sat[k]),
      .nosig   (o_nosig[k])
    );
  end
endmodule

// File: tb/tb_fps_meter_multi.sv
// tb_fps_meter_multi: scoreboard bench, two instances (DIV=1 and DIV=4) on shared stimulus
module tb_fps_meter_multi;
  typedef struct {
    int         cyc;
    logic [11:0] fps;
    logic [2:0]  sat;
    logic [2:0]  nosig;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [2:0] vs = 3'b111;
  logic [11:0] fa, fb;
  logic va, vb;
  logic [2:0] sa, sb, na, nb;
  int cyc = 0, nvec = 0, nerr = 0;
  bit low0 = 1'b0;
  exp_t qa[$], qb[$];

  fps_meter_multi #(.NUM_CH(3), .CNT_W(4), .GATE_CYCLES(100), .DIV(1), .EDGE_FALL(1'b1)) dut_a (
    .sys_clk(clk), .sys_rst(rst), .i_en(en), .i_vs(vs),
    .o_fps(fa), .o_valid(va), .o_sat(sa), .o_nosig(na));
  fps_meter_multi #(.NUM_CH(3), .CNT_W(4), .GATE_CYCLES(100), .DIV(4), .EDGE_FALL(1'b1)) dut_b (
    .sys_clk(clk), .sys_rst(rst), .i_en(en), .i_vs(vs),
    .o_fps(fb), .o_valid(vb), .o_sat(sb), .o_nosig(nb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // called on the negedge just before the first posedge of a window; returns on the next such negedge
  task automatic window(input int n0, input int n1, input int n2, input bit late0,
                        input logic [11:0] ea_fps, input logic [2:0] ea_sat, input logic [2:0] e_nosig,
                        input logic [11:0] eb_fps);
    int n[3];
    exp_t e;
    n = '{n0, n1, n2};
    for (int c = 0; c < 100; c++) begin
      for (int k = 0; k < 3; k++) vs[k] = !(c >= 4 && c < 4 + 4 * n[k] && (c - 4) % 4 < 2);
      if (late0) vs[0] = !(c >= 97);
      else if (low0) vs[0] = vs[0] & (c >= 2);
      if (c == 99) begin
        e.cyc = cyc + 1;
        e.fps = ea_fps; e.sat = ea_sat; e.nosig = e_nosig;
        qa.push_back(e);
        e.fps = eb_fps; e.sat = 3'b000;
        qb.push_back(e);
      end
      @(negedge clk);
    end
    low0 = late0;
  endtask

  task automatic run(input int n, input bit tog);
    for (int c = 0; c < n; c++) begin
      vs = (tog && c < n - 8 && c % 4 < 2) ? 3'b000 : 3'b111;
      @(negedge clk);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_fps_a"}, 32'(fa), 32'h0);
    chk({tag, "_sat_a"}, 32'(sa), 32'h0);
    chk({tag, "_nosig_a"}, 32'(na), 32'h0);
    chk({tag, "_valid_a"}, 32'(va), 32'h0);
    chk({tag, "_fps_b"}, 32'(fb), 32'h0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (va) begin
        if (qa.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL a_valid: unexpected o_valid at cycle %0d, want none", cyc);
        end else begin
          e = qa.pop_front();
          chk("a_valid_cycle", 32'(cyc), 32'(e.cyc));
          chk("a_fps", 32'(fa), 32'(e.fps));
          chk("a_sat", 32'(sa), 32'(e.sat));
          chk("a_nosig", 32'(na), 32'(e.nosig));
        end
      end
      if (vb) begin
        if (qb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL b_valid: unexpected o_valid at cycle %0d, want none", cyc);
        end else begin
          e = qb.pop_front();
          chk("b_valid_cycle", 32'(cyc), 32'(e.cyc));
          chk("b_fps", 32'(fb), 32'(e.fps));
          chk("b_sat", 32'(sb), 32'(e.sat));
          chk("b_nosig", 32'(nb), 32'(e.nosig));
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    window(0, 0, 0, 0, 12'h000, 3'b000, 3'b111, 12'h000);
    window(0, 0, 0, 0, 12'h000, 3'b000, 3'b111, 12'h000);
    window(10, 10, 0, 0, 12'h0AA, 3'b000, 3'b100, 12'h022);
    window(10, 10, 20, 0, 12'hFAA, 3'b100, 3'b000, 12'h533);
    window(10, 10, 5, 0, 12'h5AA, 3'b000, 3'b000, 12'h122);
    window(0, 10, 16, 0, 12'hFA0, 3'b100, 3'b001, 12'h430);
    window(0, 0, 0, 1, 12'h001, 3'b000, 3'b110, 12'h000);
    window(0, 0, 0, 0, 12'h000, 3'b000, 3'b111, 12'h000);
    run(50, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    rst = 1'b0;
    window(3, 0, 0, 0, 12'h003, 3'b000, 3'b110, 12'h000);
    window(1, 5, 0, 0, 12'h051, 3'b000, 3'b100, 12'h011);
    en = 1'b0;
    run(250, 1'b1);
    chk("frozen_fps_a", 32'(fa), 32'h051);
    chk("frozen_sat_a", 32'(sa), 32'h0);
    chk("frozen_nosig_a", 32'(na), 32'h4);
    chk("frozen_fps_b", 32'(fb), 32'h011);
    en = 1'b1;
    window(0, 3, 1, 0, 12'h130, 3'b000, 3'b001, 12'h000);
    run(5, 1'b0);
    chk("a_pending", 32'(qa.size()), 32'h0);
    chk("b_pending", 32'(qb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
